// File: rtl/score_pkg.sv
// Shared types and elaboration-time helpers for the BCD score counter.
package score_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int MAXW       = 4 * MAX_DIGITS;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    RUN = 1'b0,
    WON = 1'b1
  } state_t;

  // Converts a non-negative integer to packed BCD, digit 0 in the low nibble.
  function automatic logic [MAXW-1:0] int_to_bcd(input int value, input int digits);
    logic [MAXW-1:0] r;
    int              v;
    r = '0;
    v = value;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < digits) begin
        r[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end else begin
        r[4*i +: 4] = 4'd0;
      end
    end
    return r;
  endfunction

  function automatic logic bcd_gt(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b);
    logic gt;
    logic done;
    gt   = 1'b0;
    done = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (!done && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt   = (a[4*i +: 4] > b[4*i +: 4]);
        done = 1'b1;
      end else begin
        done = done;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit adder with carry in/out; results above 9 are corrected by +6.
module bcd_digit_add
  import score_pkg::*;
(
  input  bcd_t a,
  input  bcd_t b,
  input  logic cin,
  output bcd_t sum,
  output logic cout
);

  logic [4:0] raw_s;
  logic [4:0] adj_s;

  // Binary digit sum followed by decimal correction.
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    adj_s = raw_s + 5'd6;
    if (raw_s > 5'd9) begin
      sum  = adj_s[3:0];
      cout = 1'b1;
    end else begin
      sum  = raw_s[3:0];
      cout = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_score_counter.sv
// DIGITS-wide BCD score counter: combined tick+bonus increment, saturation at
// TARGET with a WON state, and a best-score register kept across rounds.
module bcd_score_counter #(
  parameter int DIGITS         = 3,
  parameter int SPEED_W        = 2,
  parameter int SCALE_BY_SPEED = 0,
  parameter int BONUS          = 10,
  parameter int TARGET         = 10**DIGITS - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                enable,
  input  logic [SPEED_W-1:0]  speed,
  input  logic                add_score,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] best,
  output logic                game_won,
  output logic                new_best
);

  import score_pkg::*;

  localparam int W     = 4 * DIGITS;
  localparam int NTICK = 2**SPEED_W;
  localparam int NIDX  = 2 * NTICK;
  localparam int LIMIT = 10**DIGITS;

  localparam logic [MAXW-1:0] TARGET_FULL = int_to_bcd(TARGET, DIGITS);
  localparam logic [W-1:0]    TARGET_BCD  = TARGET_FULL[W-1:0];

  state_t             state_r;
  logic [W-1:0]       score_r;
  logic [W-1:0]       best_r;
  logic               won_r;
  logic               new_best_r;

  logic [SPEED_W-1:0] tick_s;
  logic [SPEED_W:0]   idx_s;
  logic [W-1:0]       inc_tab_s [NIDX];
  logic [NIDX-1:0]    inc_ovf_s;
  logic [W-1:0]       inc_s;
  logic               inc_big_s;
  logic               inc_nz_s;
  logic [W-1:0]       sum_s;
  logic [DIGITS:0]    carry_s;
  logic               sat_s;
  logic               score_gt_best_s;
  logic               target_gt_best_s;

  // Every {bonus, tick} combination is a constant, so its BCD form is built at
  // elaboration; the overflow flag catches increments that alone exceed the width.
  for (genvar k = 0; k < NIDX; k++) begin : g_inc
    localparam int              VAL      = (k % NTICK) + ((k >= NTICK) ? BONUS : 0);
    localparam logic [MAXW-1:0] VAL_FULL = int_to_bcd(VAL, DIGITS);
    assign inc_tab_s[k] = VAL_FULL[W-1:0];
    assign inc_ovf_s[k] = (VAL >= LIMIT) ? 1'b1 : 1'b0;
  end

  // Tick contribution for this cycle.
  always_comb begin
    tick_s = '0;
    if (enable && (speed != '0)) begin
      if (SCALE_BY_SPEED != 0) begin
        tick_s = speed;
      end else begin
        tick_s = SPEED_W'(1'b1);
      end
    end else begin
      tick_s = '0;
    end
  end

  assign idx_s     = {add_score, tick_s};
  assign inc_s     = inc_tab_s[idx_s];
  assign inc_big_s = inc_ovf_s[idx_s];
  assign inc_nz_s  = (idx_s != '0);

  assign carry_s[0] = 1'b0;
  for (genvar d = 0; d < DIGITS; d++) begin : g_add
    bcd_digit_add u_digit (
      .a    (score_r[4*d +: 4]),
      .b    (inc_s[4*d +: 4]),
      .cin  (carry_s[d]),
      .sum  (sum_s[4*d +: 4]),
      .cout (carry_s[d+1])
    );
  end

  assign sat_s            = carry_s[DIGITS] | inc_big_s | ~bcd_gt(MAXW'(TARGET_BCD), MAXW'(sum_s));
  assign score_gt_best_s  = bcd_gt(MAXW'(score_r), MAXW'(best_r));
  assign target_gt_best_s = bcd_gt(MAXW'(TARGET_BCD), MAXW'(best_r));

  // Round FSM, score, best-score and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= RUN;
      score_r    <= '0;
      best_r     <= '0;
      won_r      <= 1'b0;
      new_best_r <= 1'b0;
    end else if (clear) begin
      state_r <= RUN;
      score_r <= '0;
      won_r   <= 1'b0;
      if ((state_r == RUN) && score_gt_best_s) begin
        best_r     <= score_r;
        new_best_r <= 1'b1;
      end else begin
        new_best_r <= 1'b0;
      end
    end else begin
      new_best_r <= 1'b0;
      case (state_r)
        RUN: begin
          if (inc_nz_s) begin
            if (sat_s) begin
              score_r <= TARGET_BCD;
              state_r <= WON;
              won_r   <= 1'b1;
              if (target_gt_best_s) begin
                best_r     <= TARGET_BCD;
                new_best_r <= 1'b1;
              end
            end else begin
              score_r <= sum_s;
            end
          end
        end
        WON: begin
          won_r <= 1'b1;
        end
        default: begin
          state_r <= RUN;
          won_r   <= 1'b0;
        end
      endcase
    end
  end

  assign score    = score_r;
  assign best     = best_r;
  assign game_won = won_r;
  assign new_best = new_best_r;

endmodule

// File: tb/tb_bcd_score_counter.sv
// Scoreboard bench: three parameterisations share one stimulus stream and an
// integer reference model queues the expected outputs for each.
module tb_bcd_score_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b0, clear = 1'b0, enable = 1'b0, add_score = 1'b0;
  logic [1:0] speed = 2'd0;

  logic [11:0] score_d, best_d, score_s, best_s, score_t, best_t;
  logic        won_d, nb_d, won_s, nb_s, won_t, nb_t;

  always #5 clk = ~clk;

  bcd_score_counter u_dflt (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .speed(speed),
    .add_score(add_score), .score(score_d), .best(best_d), .game_won(won_d), .new_best(nb_d)
  );

  bcd_score_counter #(.SCALE_BY_SPEED(1)) u_scl (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .speed(speed),
    .add_score(add_score), .score(score_s), .best(best_s), .game_won(won_s), .new_best(nb_s)
  );

  bcd_score_counter #(.TARGET(500)) u_t500 (
    .clk(clk), .reset(reset), .clear(clear), .enable(enable), .speed(speed),
    .add_score(add_score), .score(score_t), .best(best_t), .game_won(won_t), .new_best(nb_t)
  );

  typedef struct {
    int score;
    int best;
    bit won;
    bit nb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int checks   = 0;
  int failures = 0;

  int ms [3];
  int mb [3];
  bit mw [3];
  bit mnb[3];
  int tgt[3] = '{999, 999, 500};
  bit scl[3] = '{1'b0, 1'b1, 1'b0};

  // Decimal value of a 3-digit BCD word; -1 flags an illegal or unknown digit.
  function automatic int bcd2int(input logic [11:0] v);
    int r;
    r = 0;
    if ($isunknown(v)) return -1;
    for (int i = 2; i >= 0; i--) begin
      if (v[4*i +: 4] > 4'd9) return -1;
      r = r * 10 + int'(v[4*i +: 4]);
    end
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [11:0] s, input logic [11:0] b,
                     input logic w, input logic nb);
    check({tag, "_score"}, bcd2int(s), e.score);
    check({tag, "_best"}, bcd2int(b), e.best);
    check({tag, "_won"}, int'(w), int'(e.won));
    check({tag, "_newbest"}, int'(nb), int'(e.nb));
  endtask

  task automatic model(input int k, input bit r, input bit c, input bit en, input logic [1:0] sp,
                       input bit add);
    int inc;
    int sum;
    if (r) begin
      ms[k] = 0; mb[k] = 0; mw[k] = 1'b0; mnb[k] = 1'b0;
    end else if (c) begin
      mnb[k] = !mw[k] && (ms[k] > mb[k]);
      if (mnb[k]) mb[k] = ms[k];
      ms[k] = 0;
      mw[k] = 1'b0;
    end else begin
      mnb[k] = 1'b0;
      if (!mw[k]) begin
        inc = ((en && sp != 2'd0) ? (scl[k] ? int'(sp) : 1) : 0) + (add ? 10 : 0);
        if (inc != 0) begin
          sum = ms[k] + inc;
          if (sum >= tgt[k]) begin
            ms[k] = tgt[k];
            mw[k] = 1'b1;
            if (ms[k] > mb[k]) begin
              mb[k]  = ms[k];
              mnb[k] = 1'b1;
            end
          end else begin
            ms[k] = sum;
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit c, input bit en, input logic [1:0] sp, input bit add);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      model(k, r, c, en, sp, add);
      e = '{ms[k], mb[k], mw[k], mnb[k]};
      if (k == 0) q0.push_back(e);
      else if (k == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    reset = r; clear = c; enable = en; speed = sp; add_score = add;
    @(posedge clk);
    #1;
    e = q0.pop_front(); cmp("dflt", e, score_d, best_d, won_d, nb_d);
    e = q1.pop_front(); cmp("scale", e, score_s, best_s, won_s, nb_s);
    e = q2.pop_front(); cmp("t500", e, score_t, best_t, won_t, nb_t);
  endtask

  task automatic run(input int n, input bit en, input logic [1:0] sp, input bit add);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, en, sp, add);
  endtask

  initial begin
    // Reset state and 25 plain ticks.
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    check("rst_score", bcd2int(score_d), 0);
    check("rst_won", int'(won_d), 0);
    run(25, 1'b1, 2'd1, 1'b0);
    check("tick25_score", bcd2int(score_d), 25);
    check("tick25_won", int'(won_d), 0);

    // 095 plus bonus and speed-2 tick together.
    run(7, 1'b0, 2'd0, 1'b1);
    check("pre_095", bcd2int(score_d), 95);
    run(1, 1'b1, 2'd2, 1'b1);
    check("combo_dflt", bcd2int(score_d), 106);
    check("combo_scale", bcd2int(score_s), 107);
    run(1, 1'b1, 2'd0, 1'b0);
    check("speed0_hold", bcd2int(score_d), 106);

    // Saturation at 999 with carry out of the top digit.
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    run(99, 1'b0, 2'd0, 1'b1);
    run(5, 1'b1, 2'd1, 1'b0);
    check("pre_995", bcd2int(score_d), 995);
    run(1, 1'b0, 2'd0, 1'b1);
    check("sat_score", bcd2int(score_d), 999);
    check("sat_won", int'(won_d), 1);
    check("sat_best", bcd2int(best_d), 999);
    check("sat_newbest", int'(nb_d), 1);
    run(3, 1'b1, 2'd3, 1'b1);
    check("won_frozen", bcd2int(score_d), 999);
    check("won_pulse_gone", int'(nb_d), 0);

    // TARGET=500 win, clear, and best tracking across rounds.
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    run(49, 1'b0, 2'd0, 1'b1);
    run(8, 1'b1, 2'd1, 1'b0);
    run(1, 1'b1, 2'd1, 1'b0);
    check("t500_499", bcd2int(score_t), 499);
    check("t500_499_won", int'(won_t), 0);
    run(1, 1'b1, 2'd1, 1'b0);
    check("t500_500", bcd2int(score_t), 500);
    check("t500_won", int'(won_t), 1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    check("t500_clr_score", bcd2int(score_t), 0);
    check("t500_clr_won", int'(won_t), 0);
    check("t500_clr_best", bcd2int(best_t), 500);
    check("dflt_clr500_nb", int'(nb_d), 1);
    run(30, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    check("r300_no_nb", int'(nb_d), 0);
    check("r300_best", bcd2int(best_d), 500);
    run(60, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    check("r600_best", bcd2int(best_d), 600);
    check("r600_nb", int'(nb_d), 1);
    run(1, 1'b0, 2'd0, 1'b0);
    check("r600_nb_1cyc", int'(nb_d), 0);
    run(60, 1'b0, 2'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    check("equal_no_nb", int'(nb_d), 0);

    // Reset mid-round, then clear colliding with increments.
    run(45, 1'b0, 2'd0, 1'b1);
    run(6, 1'b1, 2'd1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    run(45, 1'b0, 2'd0, 1'b1);
    run(6, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    run(12, 1'b0, 2'd0, 1'b1);
    run(3, 1'b1, 2'd1, 1'b0);
    check("mid_score", bcd2int(score_d), 123);
    check("mid_best", bcd2int(best_d), 456);
    step(1'b1, 1'b0, 1'b1, 2'd1, 1'b1);
    check("midrst_score", bcd2int(score_d), 0);
    check("midrst_best", bcd2int(best_d), 0);
    check("midrst_won", int'(won_d), 0);
    run(5, 1'b1, 2'd1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    check("clr_add_score", bcd2int(score_d), 0);
    check("clr_add_scale", bcd2int(score_s), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
